// File: rtl/axi_mm_slave_mem.sv
// AXI4 memory-mapped slave backed by a 2^ADDR_WIDTH x 32-bit word memory.
// Ports:
//   axi_aclk, axi_areset       - single clock, synchronous active-high reset
//   s_axi_aw*/w*/b*            - write address, write data and write response channels
//   s_axi_ar*/r*               - read address and read data channels
//   prot/lock/cache inputs     - accepted and ignored
// Write and read paths are independent FSMs, one transaction outstanding each.
// INCR and FIXED bursts of 32-bit beats are supported; WRAP, reserved bursts and
// non-32-bit sizes complete normally but report SLVERR, write nothing and read zero.
module axi_mm_slave_mem #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter bit          INIT_ZERO  = 1'b1
) (
  input  logic        axi_aclk,
  input  logic        axi_areset,
  input  logic [31:0] s_axi_awaddr,
  input  logic [7:0]  s_axi_awlen,
  input  logic [2:0]  s_axi_awsize,
  input  logic [1:0]  s_axi_awburst,
  input  logic [2:0]  s_axi_awprot,
  input  logic        s_axi_awlock,
  input  logic [3:0]  s_axi_awcache,
  input  logic        s_axi_awvalid,
  output logic        s_axi_awready,
  input  logic [31:0] s_axi_wdata,
  input  logic [3:0]  s_axi_wstrb,
  input  logic        s_axi_wlast,
  input  logic        s_axi_wvalid,
  output logic        s_axi_wready,
  output logic [1:0]  s_axi_bresp,
  output logic        s_axi_bvalid,
  input  logic        s_axi_bready,
  input  logic [31:0] s_axi_araddr,
  input  logic [7:0]  s_axi_arlen,
  input  logic [2:0]  s_axi_arsize,
  input  logic [1:0]  s_axi_arburst,
  input  logic [2:0]  s_axi_arprot,
  input  logic        s_axi_arlock,
  input  logic [3:0]  s_axi_arcache,
  input  logic        s_axi_arvalid,
  output logic        s_axi_arready,
  output logic [31:0] s_axi_rdata,
  output logic [1:0]  s_axi_rresp,
  output logic        s_axi_rlast,
  output logic        s_axi_rvalid,
  input  logic        s_axi_rready
);

  localparam int unsigned Depth   = 2 ** ADDR_WIDTH;
  localparam logic [1:0]  RespOk  = 2'b00;
  localparam logic [1:0]  RespErr = 2'b10;
  localparam logic [1:0]  BurstIncr = 2'b01;

  typedef logic [ADDR_WIDTH-1:0] idx_t;
  typedef logic [31:0] mem_t [Depth];

  // Power-up contents only; reset never touches the array.
  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < Depth; i++) m[i] = INIT_ZERO ? 32'h0 : 32'hx;
    return m;
  endfunction

  mem_t mem_q = mem_init();

  typedef enum logic [1:0] {WIdle, WData, WResp} w_state_e;
  typedef enum logic [0:0] {RIdle, RData} r_state_e;

  w_state_e    w_state_q, w_state_d;
  idx_t        widx_q, widx_d;
  logic [7:0]  wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic [1:0]  wburst_q, wburst_d, bresp_q, bresp_d;
  logic        werr_q, werr_d, mem_we;

  r_state_e    r_state_q, r_state_d;
  idx_t        ridx_q, ridx_d;
  logic [7:0]  rlen_q, rlen_d, rcnt_q, rcnt_d;
  logic [1:0]  rburst_q, rburst_d, rresp_q, rresp_d;
  logic        rerr_q, rerr_d, rwait_q, rwait_d;
  logic        rvalid_q, rvalid_d, rlast_q, rlast_d;
  logic [31:0] rdata_q, rdata_d;

  // Write path
  always_comb begin
    w_state_d = w_state_q;
    widx_d    = widx_q;
    wlen_d    = wlen_q;
    wburst_d  = wburst_q;
    werr_d    = werr_q;
    wcnt_d    = wcnt_q;
    bresp_d   = bresp_q;
    mem_we    = 1'b0;
    case (w_state_q)
      WIdle: begin
        if (s_axi_awvalid) begin
          widx_d    = s_axi_awaddr[ADDR_WIDTH+1:2];
          wlen_d    = s_axi_awlen;
          wburst_d  = s_axi_awburst;
          werr_d    = (s_axi_awsize != 3'b010) || s_axi_awburst[1];
          wcnt_d    = 8'd0;
          w_state_d = WData;
        end
      end
      WData: begin
        if (s_axi_wvalid) begin
          mem_we = ~werr_q;
          wcnt_d = wcnt_q + 8'd1;
          if (wburst_q == BurstIncr) widx_d = widx_q + 1'b1;
          if (s_axi_wlast) begin
            // wcnt_q is the zero-based number of this beat, so it must equal awlen
            bresp_d   = (werr_q || (wcnt_q != wlen_q)) ? RespErr : RespOk;
            w_state_d = WResp;
          end
        end
      end
      WResp: begin
        if (s_axi_bready) w_state_d = WIdle;
      end
      default: w_state_d = WIdle;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      w_state_q <= WIdle;
      widx_q    <= '0;
      wlen_q    <= '0;
      wburst_q  <= '0;
      werr_q    <= 1'b0;
      wcnt_q    <= '0;
      bresp_q   <= '0;
    end else begin
      w_state_q <= w_state_d;
      widx_q    <= widx_d;
      wlen_q    <= wlen_d;
      wburst_q  <= wburst_d;
      werr_q    <= werr_d;
      wcnt_q    <= wcnt_d;
      bresp_q   <= bresp_d;
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (mem_we && !axi_areset) begin
      for (int b = 0; b < 4; b++) begin
        if (s_axi_wstrb[b]) mem_q[widx_q][8*b +: 8] <= s_axi_wdata[8*b +: 8];
      end
    end
  end

  // Read path. rwait_q inserts one idle cycle so the first beat lands two cycles
  // after the address handshake. The output register only loads when empty or
  // being accepted, so it doubles as the stall-hold register.
  always_comb begin
    r_state_d = r_state_q;
    ridx_d    = ridx_q;
    rlen_d    = rlen_q;
    rburst_d  = rburst_q;
    rerr_d    = rerr_q;
    rcnt_d    = rcnt_q;
    rwait_d   = rwait_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    rlast_d   = rlast_q;
    case (r_state_q)
      RIdle: begin
        if (s_axi_arvalid) begin
          ridx_d    = s_axi_araddr[ADDR_WIDTH+1:2];
          rlen_d    = s_axi_arlen;
          rburst_d  = s_axi_arburst;
          rerr_d    = (s_axi_arsize != 3'b010) || s_axi_arburst[1];
          rcnt_d    = 8'd0;
          rwait_d   = 1'b1;
          r_state_d = RData;
        end
      end
      RData: begin
        if (rwait_q) begin
          rwait_d = 1'b0;
        end else if (!rvalid_q || s_axi_rready) begin
          if (rvalid_q && rlast_q) begin
            rvalid_d  = 1'b0;
            rlast_d   = 1'b0;
            r_state_d = RIdle;
          end else begin
            // mem_q sampled before any same-edge write commits: old data wins
            rvalid_d = 1'b1;
            rdata_d  = rerr_q ? 32'h0 : mem_q[ridx_q];
            rresp_d  = rerr_q ? RespErr : RespOk;
            rlast_d  = (rcnt_q == rlen_q);
            rcnt_d   = rcnt_q + 8'd1;
            if (rburst_q == BurstIncr) ridx_d = ridx_q + 1'b1;
          end
        end
      end
      default: r_state_d = RIdle;
    endcase
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      r_state_q <= RIdle;
      ridx_q    <= '0;
      rlen_q    <= '0;
      rburst_q  <= '0;
      rerr_q    <= 1'b0;
      rcnt_q    <= '0;
      rwait_q   <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= '0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      ridx_q    <= ridx_d;
      rlen_q    <= rlen_d;
      rburst_q  <= rburst_d;
      rerr_q    <= rerr_d;
      rcnt_q    <= rcnt_d;
      rwait_q   <= rwait_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      rlast_q   <= rlast_d;
    end
  end

  // Outputs are forced quiet while reset is high, including the first reset cycle.
  assign s_axi_awready = (w_state_q == WIdle) && !axi_areset;
  assign s_axi_wready  = (w_state_q == WData) && !axi_areset;
  assign s_axi_bvalid  = (w_state_q == WResp) && !axi_areset;
  assign s_axi_bresp   = axi_areset ? 2'b00 : bresp_q;
  assign s_axi_arready = (r_state_q == RIdle) && !axi_areset;
  assign s_axi_rvalid  = rvalid_q && !axi_areset;
  assign s_axi_rlast   = rlast_q && !axi_areset;
  assign s_axi_rresp   = axi_areset ? 2'b00 : rresp_q;
  assign s_axi_rdata   = axi_areset ? 32'h0 : rdata_q;

  logic unused_inputs;
  assign unused_inputs = ^{s_axi_awaddr[31:ADDR_WIDTH+2], s_axi_awaddr[1:0],
                           s_axi_araddr[31:ADDR_WIDTH+2], s_axi_araddr[1:0],
                           s_axi_awprot, s_axi_awlock, s_axi_awcache,
                           s_axi_arprot, s_axi_arlock, s_axi_arcache};

endmodule

// File: tb/tb_axi_mm_slave_mem.sv
module tb_axi_mm_slave_mem;

  logic        clk = 1'b0;
  logic        axi_areset;
  logic [31:0] s_axi_awaddr, s_axi_wdata, s_axi_araddr, s_axi_rdata;
  logic [7:0]  s_axi_awlen, s_axi_arlen;
  logic [2:0]  s_axi_awsize, s_axi_arsize;
  logic [1:0]  s_axi_awburst, s_axi_arburst, s_axi_bresp, s_axi_rresp;
  logic        s_axi_awvalid, s_axi_awready, s_axi_wlast, s_axi_wvalid, s_axi_wready;
  logic        s_axi_bvalid, s_axi_bready, s_axi_arvalid, s_axi_arready;
  logic        s_axi_rlast, s_axi_rvalid, s_axi_rready;
  logic [3:0]  s_axi_wstrb;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] wd [256];
  logic [31:0] rd_data [256];
  logic [1:0]  rd_resp [256];
  logic        rd_last [256];
  int          rd_n;
  int          rd_lat;
  bit          rd_stable;

  always #5 clk = ~clk;

  axi_mm_slave_mem dut (
    .axi_aclk      (clk),
    .axi_areset    (axi_areset),
    .s_axi_awaddr  (s_axi_awaddr),
    .s_axi_awlen   (s_axi_awlen),
    .s_axi_awsize  (s_axi_awsize),
    .s_axi_awburst (s_axi_awburst),
    .s_axi_awprot  (3'b000),
    .s_axi_awlock  (1'b0),
    .s_axi_awcache (4'b0000),
    .s_axi_awvalid (s_axi_awvalid),
    .s_axi_awready (s_axi_awready),
    .s_axi_wdata   (s_axi_wdata),
    .s_axi_wstrb   (s_axi_wstrb),
    .s_axi_wlast   (s_axi_wlast),
    .s_axi_wvalid  (s_axi_wvalid),
    .s_axi_wready  (s_axi_wready),
    .s_axi_bresp   (s_axi_bresp),
    .s_axi_bvalid  (s_axi_bvalid),
    .s_axi_bready  (s_axi_bready),
    .s_axi_araddr  (s_axi_araddr),
    .s_axi_arlen   (s_axi_arlen),
    .s_axi_arsize  (s_axi_arsize),
    .s_axi_arburst (s_axi_arburst),
    .s_axi_arprot  (3'b000),
    .s_axi_arlock  (1'b0),
    .s_axi_arcache (4'b0000),
    .s_axi_arvalid (s_axi_arvalid),
    .s_axi_arready (s_axi_arready),
    .s_axi_rdata   (s_axi_rdata),
    .s_axi_rresp   (s_axi_rresp),
    .s_axi_rlast   (s_axi_rlast),
    .s_axi_rvalid  (s_axi_rvalid),
    .s_axi_rready  (s_axi_rready)
  );

  // Called at a negedge; returns at a negedge with the response accepted.
  task automatic axi_write(input logic [31:0] addr, input logic [7:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input logic [3:0] strb, input int nbeats,
                           output logic [1:0] bresp, output logic b_on_time);
    int n;
    s_axi_awaddr = addr; s_axi_awlen = len; s_axi_awsize = size; s_axi_awburst = burst;
    s_axi_awvalid = 1'b1;
    n = 0;
    while (!s_axi_awready && n < 100) begin @(negedge clk); n++; end
    @(negedge clk);
    s_axi_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      s_axi_wdata = wd[i]; s_axi_wstrb = strb; s_axi_wlast = (i == nbeats - 1);
      s_axi_wvalid = 1'b1;
      n = 0;
      while (!s_axi_wready && n < 100) begin @(negedge clk); n++; end
      @(negedge clk);
    end
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    b_on_time = s_axi_bvalid;
    n = 0;
    while (!s_axi_bvalid && n < 100) begin @(negedge clk); n++; end
    bresp = s_axi_bvalid ? s_axi_bresp : 2'bxx;
    @(negedge clk);
  endtask

  // Called at a negedge; fills rd_* and measures first-beat latency in clock edges.
  task automatic axi_read(input logic [31:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input bit toggle);
    int n;
    bit phase, stalled;
    logic [31:0] held;
    s_axi_araddr = addr; s_axi_arlen = len; s_axi_arsize = 3'b010; s_axi_arburst = burst;
    s_axi_arvalid = 1'b1;
    n = 0;
    while (!s_axi_arready && n < 100) begin @(negedge clk); n++; end
    @(posedge clk);
    rd_lat = 0;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    while (!s_axi_rvalid && rd_lat < 20) begin
      @(posedge clk); rd_lat++; @(negedge clk);
    end
    rd_n = 0; rd_stable = 1'b1; phase = 1'b0; stalled = 1'b0; held = '0; n = 0;
    while (rd_n < int'(len) + 1 && n < 3000) begin
      if (stalled && s_axi_rdata !== held) rd_stable = 1'b0;
      s_axi_rready = toggle ? phase : 1'b1;
      phase = !phase;
      if (s_axi_rvalid && s_axi_rready) begin
        rd_data[rd_n] = s_axi_rdata; rd_resp[rd_n] = s_axi_rresp; rd_last[rd_n] = s_axi_rlast;
        rd_n++; stalled = 1'b0;
      end else if (s_axi_rvalid) begin
        stalled = 1'b1; held = s_axi_rdata;
      end
      @(negedge clk); n++;
    end
    s_axi_rready = 1'b1;
  endtask

  task automatic test_reset();
    axi_areset = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rlast}
        !== 6'b0 || s_axi_rdata !== 32'h0 || s_axi_bresp !== 2'b00 || s_axi_rresp !== 2'b00) begin
      tests_failed++;
      $display("FAIL reset_outputs: got aw=%b w=%b b=%b ar=%b r=%b rdata=%h, required all 0",
               s_axi_awready, s_axi_wready, s_axi_bvalid, s_axi_arready, s_axi_rvalid, s_axi_rdata);
    end
    axi_areset = 1'b0;
    #1;
    tests_run++;
    if (s_axi_awready !== 1'b1 || s_axi_arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_release_ready: got awready=%b arready=%b, required 1 1",
               s_axi_awready, s_axi_arready);
    end
    @(negedge clk);
  endtask

  task automatic test_incr();
    logic [1:0] br; logic ot; int bad;
    for (int i = 0; i < 4; i++) wd[i] = 32'hA0 + i;
    axi_write(32'h10, 8'd3, 3'b010, 2'b01, 4'hF, 4, br, ot);
    tests_run++;
    if (br !== 2'b00 || ot !== 1'b1) begin
      tests_failed++;
      $display("FAIL incr_bresp: got bresp=%b on_time=%b, required 00 1", br, ot);
    end
    axi_read(32'h10, 8'd3, 2'b01, 1'b0);
    tests_run++;
    if (rd_lat != 2) begin
      tests_failed++;
      $display("FAIL incr_read_latency: got %0d, required 2", rd_lat);
    end
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (rd_data[i] !== 32'hA0 + i || rd_resp[i] !== 2'b00 || rd_last[i] !== (i == 3)) bad++;
    tests_run++;
    if (rd_n != 4 || bad != 0) begin
      tests_failed++;
      $display("FAIL incr_read_data: got %0d beats %0d bad (d0=%h d3=%h), required 4 beats 0 bad",
               rd_n, bad, rd_data[0], rd_data[3]);
    end
    tests_run++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b1) begin
      tests_failed++;
      $display("FAIL incr_read_done: got rvalid=%b arready=%b, required 0 1",
               s_axi_rvalid, s_axi_arready);
    end
  endtask

  task automatic test_strobe();
    logic [1:0] br; logic ot;
    wd[0] = 32'hDEADBEEF;
    axi_write(32'h40, 8'd0, 3'b010, 2'b01, 4'hF, 1, br, ot);
    wd[0] = 32'h11223344;
    axi_write(32'h40, 8'd0, 3'b010, 2'b01, 4'b0101, 1, br, ot);
    axi_read(32'h40, 8'd0, 2'b01, 1'b0);
    tests_run++;
    if (rd_data[0] !== 32'hDE22BE44 || rd_last[0] !== 1'b1) begin
      tests_failed++;
      $display("FAIL strobe_merge: got %h last=%b, required DE22BE44 1", rd_data[0], rd_last[0]);
    end
  endtask

  task automatic test_stall();
    logic [1:0] br; logic ot; int bad;
    for (int i = 0; i < 8; i++) wd[i] = 32'h1000 + i;
    axi_write(32'h100, 8'd7, 3'b010, 2'b01, 4'hF, 8, br, ot);
    axi_read(32'h100, 8'd7, 2'b01, 1'b1);
    bad = 0;
    for (int i = 0; i < 8; i++)
      if (rd_data[i] !== 32'h1000 + i || rd_last[i] !== (i == 7)) bad++;
    tests_run++;
    if (rd_n != 8 || bad != 0) begin
      tests_failed++;
      $display("FAIL stall_order: got %0d beats %0d bad, required 8 beats 0 bad", rd_n, bad);
    end
    tests_run++;
    if (rd_stable !== 1'b1) begin
      tests_failed++;
      $display("FAIL stall_hold: got rdata changed while stalled, required stable");
    end
  endtask

  task automatic test_errors();
    logic [1:0] br; logic ot; int bad;
    wd[0] = 32'hFFFFFFFF; wd[1] = 32'hFFFFFFFF;
    axi_write(32'h10, 8'd1, 3'b010, 2'b10, 4'hF, 2, br, ot);
    tests_run++;
    if (br !== 2'b10) begin
      tests_failed++;
      $display("FAIL wrap_write_bresp: got %b, required 10", br);
    end
    axi_write(32'h14, 8'd0, 3'b001, 2'b01, 4'hF, 1, br, ot);
    tests_run++;
    if (br !== 2'b10) begin
      tests_failed++;
      $display("FAIL size_write_bresp: got %b, required 10", br);
    end
    axi_read(32'h10, 8'd1, 2'b01, 1'b0);
    tests_run++;
    if (rd_data[0] !== 32'hA0 || rd_data[1] !== 32'hA1) begin
      tests_failed++;
      $display("FAIL error_write_unchanged: got %h %h, required 000000a0 000000a1",
               rd_data[0], rd_data[1]);
    end
    axi_read(32'h10, 8'd3, 2'b10, 1'b0);
    bad = 0;
    for (int i = 0; i < 4; i++)
      if (rd_data[i] !== 32'h0 || rd_resp[i] !== 2'b10 || rd_last[i] !== (i == 3)) bad++;
    tests_run++;
    if (rd_n != 4 || bad != 0) begin
      tests_failed++;
      $display("FAIL wrap_read: got %0d beats %0d bad, required 4 beats 0 bad", rd_n, bad);
    end
  endtask

  task automatic test_early_wlast();
    logic [1:0] br; logic ot;
    wd[0] = 32'h0; wd[1] = 32'h0;
    axi_write(32'h500, 8'd3, 3'b010, 2'b01, 4'hF, 2, br, ot);
    tests_run++;
    if (br !== 2'b10 || s_axi_awready !== 1'b1 || s_axi_wready !== 1'b0) begin
      tests_failed++;
      $display("FAIL early_wlast: got bresp=%b awready=%b wready=%b, required 10 1 0",
               br, s_axi_awready, s_axi_wready);
    end
  endtask

  task automatic test_index_wrap();
    logic [1:0] br; logic ot;
    wd[0] = 32'h55; wd[1] = 32'h66;
    axi_write(32'hFFC, 8'd1, 3'b010, 2'b01, 4'hF, 2, br, ot);
    axi_read(32'hFFC, 8'd0, 2'b01, 1'b0);
    tests_run++;
    if (rd_data[0] !== 32'h55) begin
      tests_failed++;
      $display("FAIL index_wrap_last: got %h, required 00000055", rd_data[0]);
    end
    axi_read(32'h1000, 8'd0, 2'b01, 1'b0);
    tests_run++;
    if (rd_data[0] !== 32'h66) begin
      tests_failed++;
      $display("FAIL index_wrap_zero: got %h, required 00000066", rd_data[0]);
    end
  endtask

  task automatic test_fixed();
    logic [1:0] br; logic ot;
    wd[0] = 32'h1; wd[1] = 32'h2; wd[2] = 32'h3;
    axi_write(32'h200, 8'd2, 3'b010, 2'b00, 4'hF, 3, br, ot);
    axi_read(32'h200, 8'd1, 2'b01, 1'b0);
    tests_run++;
    if (br !== 2'b00 || rd_data[0] !== 32'h3 || rd_data[1] !== 32'h0) begin
      tests_failed++;
      $display("FAIL fixed_burst: got bresp=%b %h %h, required 00 00000003 00000000",
               br, rd_data[0], rd_data[1]);
    end
  endtask

  task automatic test_len255();
    logic [1:0] br; logic ot; int bad;
    for (int i = 0; i < 256; i++) wd[i] = 32'h5A000000 | i;
    axi_write(32'h800, 8'd255, 3'b010, 2'b01, 4'hF, 256, br, ot);
    axi_read(32'h800, 8'd255, 2'b01, 1'b0);
    bad = 0;
    for (int i = 0; i < 256; i++)
      if (rd_data[i] !== (32'h5A000000 | i) || rd_last[i] !== (i == 255)) bad++;
    tests_run++;
    if (br !== 2'b00 || rd_n != 256 || bad != 0) begin
      tests_failed++;
      $display("FAIL len255: got bresp=%b %0d beats %0d bad, required 00 256 beats 0 bad",
               br, rd_n, bad);
    end
  endtask

  task automatic test_same_cycle();
    logic [1:0] br; logic ot;
    wd[0] = 32'h11111111;
    axi_write(32'h300, 8'd0, 3'b010, 2'b01, 4'hF, 1, br, ot);
    s_axi_awaddr = 32'h300; s_axi_awlen = 8'd0; s_axi_awsize = 3'b010; s_axi_awburst = 2'b01;
    s_axi_araddr = 32'h300; s_axi_arlen = 8'd0; s_axi_arsize = 3'b010; s_axi_arburst = 2'b01;
    s_axi_awvalid = 1'b1; s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_awvalid = 1'b0; s_axi_arvalid = 1'b0;
    @(negedge clk);
    s_axi_wdata = 32'h22222222; s_axi_wstrb = 4'hF; s_axi_wlast = 1'b1; s_axi_wvalid = 1'b1;
    @(negedge clk);
    s_axi_wvalid = 1'b0; s_axi_wlast = 1'b0;
    tests_run++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h11111111 || s_axi_bvalid !== 1'b1) begin
      tests_failed++;
      $display("FAIL same_cycle_old: got rvalid=%b rdata=%h bvalid=%b, required 1 11111111 1",
               s_axi_rvalid, s_axi_rdata, s_axi_bvalid);
    end
    @(negedge clk);
    axi_read(32'h300, 8'd0, 2'b01, 1'b0);
    tests_run++;
    if (rd_data[0] !== 32'h22222222) begin
      tests_failed++;
      $display("FAIL same_cycle_new: got %h, required 22222222", rd_data[0]);
    end
  endtask

  task automatic test_reset_mid_read();
    int n;
    s_axi_araddr = 32'h100; s_axi_arlen = 8'd7; s_axi_arsize = 3'b010; s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b1; s_axi_rready = 1'b1;
    @(negedge clk);
    s_axi_arvalid = 1'b0;
    n = 0;
    while (!s_axi_rvalid && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    tests_run++;
    if (s_axi_rvalid !== 1'b1 || s_axi_rdata !== 32'h1001) begin
      tests_failed++;
      $display("FAIL mid_read_beat2: got rvalid=%b rdata=%h, required 1 00001001",
               s_axi_rvalid, s_axi_rdata);
    end
    axi_areset = 1'b1;
    @(negedge clk);
    tests_run++;
    if (s_axi_rvalid !== 1'b0 || s_axi_arready !== 1'b0 || s_axi_rlast !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_read_reset: got rvalid=%b arready=%b rlast=%b, required 0 0 0",
               s_axi_rvalid, s_axi_arready, s_axi_rlast);
    end
    @(negedge clk);
    axi_areset = 1'b0;
    #1;
    tests_run++;
    if (s_axi_arready !== 1'b1 || s_axi_awready !== 1'b1 || s_axi_rvalid !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_read_release: got arready=%b awready=%b rvalid=%b, required 1 1 0",
               s_axi_arready, s_axi_awready, s_axi_rvalid);
    end
    @(negedge clk);
    axi_read(32'h100, 8'd0, 2'b01, 1'b0);
    tests_run++;
    if (rd_data[0] !== 32'h1000) begin
      tests_failed++;
      $display("FAIL mid_read_mem_kept: got %h, required 00001000", rd_data[0]);
    end
  endtask

  initial begin
    axi_areset = 1'b1;
    s_axi_awaddr = '0; s_axi_awlen = '0; s_axi_awsize = 3'b010; s_axi_awburst = 2'b01;
    s_axi_awvalid = 1'b0; s_axi_wdata = '0; s_axi_wstrb = '0; s_axi_wlast = 1'b0;
    s_axi_wvalid = 1'b0; s_axi_bready = 1'b1;
    s_axi_araddr = '0; s_axi_arlen = '0; s_axi_arsize = 3'b010; s_axi_arburst = 2'b01;
    s_axi_arvalid = 1'b0; s_axi_rready = 1'b1;
    @(negedge clk);
    test_reset();
    test_incr();
    test_strobe();
    test_stall();
    test_errors();
    test_early_wlast();
    test_index_wrap();
    test_fixed();
    test_len255();
    test_same_cycle();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/axi_mm_slave_mem.md
AXI_MM_SLAVE_MEM -- requirements
Module: axi_mm_slave_mem

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address width; internal memory is 2^ADDR_WIDTH x 32-bit words.
REQ-002 Parameter INIT_ZERO, default 1; memory contents are zero at time 0 (simulation/FPGA init), not cleared by reset.
REQ-003 The block SHALL use a single clock and a synchronous, active-high reset.
REQ-004 Ports, clock and reset first:
- axi_aclk  in  1  clock
- axi_areset  in  1  sync reset, active high
- s_axi_awaddr/awlen/awsize/awburst  in  32/8/3/2  write address
- s_axi_awvalid  in  1
- s_axi_awready  out  1
- s_axi_wdata/wstrb  in  32/4
- s_axi_wlast, s_axi_wvalid  in  1 each
- s_axi_wready  out  1
- s_axi_bresp  out  2
- s_axi_bvalid  out  1
- s_axi_bready  in  1
- s_axi_araddr/arlen/arsize/arburst  in  32/8/3/2  read address
- s_axi_arvalid  in  1
- s_axi_arready  out  1
- s_axi_rdata  out  32
- s_axi_rresp  out  2
- s_axi_rlast, s_axi_rvalid  out  1 each
- s_axi_rready  in  1
- awprot/awlock/awcache/arprot/arlock/arcache  in  3/1/4 each; accepted and ignored.

Function
REQ-005 The write and read paths SHALL be independent FSMs, each with one transaction outstanding.
REQ-006 Word index = addr[ADDR_WIDTH+1:2]; upper address bits are ignored (aliasing); addr[1:0] is ignored.
REQ-007 Write FSM states: W_IDLE (awready=1), W_DATA (wready=1), W_RESP (bvalid=1).
REQ-008 W_IDLE->W_DATA on awvalid&awready; latch word index, awlen, awburst, error flag.
REQ-009 Error flag = (awsize!=3'b010) or (awburst==2'b10 WRAP or 2'b11); on error all beats are accepted, no memory bytes are written.
REQ-010 In W_DATA, each wvalid&wready beat writes the bytes enabled by wstrb; INCR advances the index by 1 (wraps modulo 2^ADDR_WIDTH), FIXED holds it.
REQ-011 An 8-bit beat counter SHALL count W beats; W_DATA->W_RESP on the beat carrying wlast=1.
REQ-012 bresp=SLVERR (2'b10) if error flag set or wlast beat count != awlen+1, else OKAY; bvalid asserts the cycle after the wlast handshake.
REQ-013 W_RESP->W_IDLE on bvalid&bready; bvalid/bresp held stable until accepted.
REQ-014 Read FSM states: R_IDLE (arready=1), R_DATA; latch index, arlen, arburst, error flag (same rule as REQ-009).
REQ-015 First rvalid SHALL assert exactly 2 cycles after the ar handshake; with rready held high beats are back-to-back, one per cycle.
REQ-016 When rvalid=1 and rready=0, rdata/rresp/rlast SHALL hold stable (skid register, no beat lost or repeated).
REQ-017 rlast=1 only on beat arlen+1; R_DATA->R_IDLE on that beat's handshake; arready reasserts the next cycle.
REQ-018 On read error rdata=0, rresp=SLVERR for all arlen+1 beats; otherwise rresp=OKAY.
REQ-019 Simultaneous write and read to the same word in the same cycle: read returns pre-write data.
REQ-020 awlen/arlen=0 (single beat) and 255 (256 beats) SHALL both be supported.

Reset
REQ-021 While axi_areset=1: awready, wready, bvalid, arready, rvalid, rlast=0; bresp, rresp, rdata=0; FSMs in IDLE; counters 0.
REQ-022 awready and arready SHALL be 1 in the first cycle after reset deasserts.
REQ-023 Reset mid-burst SHALL abort both transactions with no further handshakes; bytes already written remain.

Verification
REQ-024 INCR write awaddr=0x10, awlen=3, wdata 0xA0..0xA3, wstrb=4'hF -> bresp=OKAY one cycle after wlast; INCR read of same -> 0xA0..0xA3, rlast on 4th beat, first rvalid 2 cycles after ar handshake.
REQ-025 Write 0xDEADBEEF then single beat wstrb=4'b0101 data 0x11223344 -> readback 0xDE22BE44.
REQ-026 Read awlen=7 with rready toggling 1/0 each cycle -> 8 beats, in order, none duplicated, data stable while stalled.
REQ-027 awburst=WRAP or awsize=3'b001 -> bresp=SLVERR, memory unchanged; arburst=WRAP -> arlen+1 beats rdata=0 rresp=SLVERR.
REQ-028 awlen=3 with wlast on beat 2 -> bresp=SLVERR, FSM back in W_IDLE; INCR write from last word (index 2^ADDR_WIDTH-1) len=1 -> second beat lands at index 0.
REQ-029 Reset asserted mid-read burst (beat 2 of 8) -> rvalid=0 next cycle, arready=1 first cycle after reset release.
